rs_alloc_sched: RTL and testbench
=================================

RS_ALLOC_SCHED -- requirements
Module: rs_alloc_sched

Interface
REQ-001 SHALL have parameter RS_V_SIZE, default 4, number of vector reservation-station entries.
REQ-002 SHALL have parameter RS_S_SIZE, default 4, number of scalar reservation-station entries.
REQ-003 SHALL have parameter IDX_W, default 2, entry-index width; must satisfy 2**IDX_W >= max(RS_V_SIZE, RS_S_SIZE).
REQ-004 SHALL have port clk  in  1  sole clock; all state updates on its rising edge.
REQ-005 SHALL have port rst_n  in  1  reset, asynchronous, active-low.
REQ-006 SHALL have port alloc_v_req  in  1  decode requests one vector RS entry this cycle.
REQ-007 SHALL have port alloc_s_req  in  1  decode requests one scalar RS entry this cycle.
REQ-008 SHALL have port alloc_v_gnt / alloc_s_gnt  out  1  request granted this cycle.
REQ-009 SHALL have port alloc_v_idx / alloc_s_idx  out  IDX_W  granted entry index.
REQ-010 SHALL have port ready_v  in  RS_V_SIZE  per-entry operands-ready, from wakeup logic.
REQ-011 SHALL have port ready_s  in  RS_S_SIZE  per-entry operands-ready.
REQ-012 SHALL have port disp_v_valid / disp_s_valid  out  1  entry offered to the execute unit.
REQ-013 SHALL have port disp_v_idx / disp_s_idx  out  IDX_W  offered entry index.
REQ-014 SHALL have port disp_v_ack / disp_s_ack  in  1  execute unit accepts the offered entry.
REQ-015 SHALL have port flush  in  1  branch (bne) redirect; discard all entries.
REQ-016 SHALL have port busy_v  out  RS_V_SIZE; busy_s  out  RS_S_SIZE  per-entry occupied flags.
REQ-017 SHALL have port v_full / s_full  out  1  all entries of the pool busy.
REQ-018 SHALL have port decoder_stall  out  1  decode must hold its current instruction.

Function (each pool behaves identically and independently, except flush)
REQ-019 Allocation SHALL be combinational: gnt = req & ~full & ~flush; idx = lowest-numbered non-busy entry; idx = 0 when gnt = 0.
REQ-020 A granted entry SHALL become busy at the next rising edge; at most one allocation per pool per cycle.
REQ-021 full SHALL equal AND of the pool busy bits, computed from current registered state.
REQ-022 decoder_stall SHALL equal (alloc_v_req & v_full) | (alloc_s_req & s_full) | flush.
REQ-023 The scheduler SHALL record allocation order per pool (age matrix or equivalent); candidates = busy & ready & not currently offered.
REQ-024 Dispatch selection SHALL pick the earliest-allocated candidate; ties cannot occur.
REQ-025 disp_valid/disp_idx SHALL be registered; at an edge where disp_valid = 0 or ack = 1, they load the selection (valid = 0 if none).
REQ-026 While disp_valid = 1 and ack = 0, disp_idx SHALL hold stable, even if ready for that entry drops.
REQ-027 On ack with disp_valid = 1, the offered entry's busy bit SHALL clear at that edge; back-to-back dispatch with no bubble is required.
REQ-028 ack while disp_valid = 0 SHALL be ignored.
REQ-029 An entry freed at edge N SHALL be allocatable from cycle N+1; allocation never selects an entry being freed in the same cycle.
REQ-030 An entry allocated at edge N SHALL be dispatch-eligible no earlier than cycle N+1, with disp_valid from edge N+1 at the earliest.
REQ-031 flush SHALL be synchronous: at the edge, all busy bits, ages and disp_valid clear; flush overrides alloc and ack in the same cycle.

Reset
REQ-032 rst_n low SHALL immediately force: busy_v = busy_s = 0, ages cleared, disp_*_valid = 0, disp_*_idx = 0, full = 0.
REQ-033 While rst_n is low, alloc_*_gnt SHALL be 0; reset asserted mid-dispatch discards the offer with no ack needed.

Verification
REQ-034 After reset, alloc_v_req high for 5 cycles -> gnt idx 0,1,2,3; cycle 5 v_full = 1, gnt = 0, decoder_stall = 1.
REQ-035 Entries 0-3 busy (allocated in order 0..3), ready_v = 4'b1010 -> disp_v_idx = 1; ack -> next cycle disp_v_idx = 3, busy_v = 4'b1101; ack -> busy_v = 4'b0101.
REQ-036 Pool full, alloc_v_req held, ack offered entry 2 -> that cycle gnt = 0; next cycle gnt = 1, idx = 2.
REQ-037 Allocate 0,1,2; dispatch/ack 0; allocate 0 again; ready all -> dispatch order 1, 2, 0.
REQ-038 flush together with alloc_s_req and disp_s_ack -> gnt = 0, stall = 1; next cycle all busy = 0, disp valid = 0.
REQ-039 rst_n driven low between clock edges while disp_v_valid = 1 -> disp_v_valid and busy_v go 0 before the next edge.

Source files
------------

// File: rtl/rs_alloc_sched.sv
// Vector/scalar reservation-station allocator and dispatch scheduler.
// Each pool allocates its lowest free entry and offers its oldest ready entry.
module rs_pool #(
    parameter int unsigned SIZE  = 4,
    parameter int unsigned IDX_W = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic             alloc_req,
    output logic             alloc_gnt,
    output logic [IDX_W-1:0] alloc_idx,
    input  logic [SIZE-1:0]  ready,
    output logic             disp_valid,
    output logic [IDX_W-1:0] disp_idx,
    input  logic             disp_ack,
    output logic [SIZE-1:0]  busy,
    output logic             full
);
    // older[j][i] is set when entry j was allocated before entry i
    logic [SIZE-1:0][SIZE-1:0] older;
    logic [SIZE-1:0]           cand;
    logic [IDX_W-1:0]          free_idx;
    logic [IDX_W-1:0]          sel_idx;
    logic                      free_found;
    logic                      sel_found;
    logic                      beaten;
    logic                      release_en;

    assign full       = &busy;
    assign alloc_gnt  = alloc_req & ~full & ~flush & rst_n;
    assign alloc_idx  = alloc_gnt ? free_idx : '0;
    assign release_en = disp_valid & disp_ack;

    always_comb begin
        free_idx   = '0;
        free_found = 1'b0;
        for (int unsigned i = 0; i < SIZE; i++) begin
            if (!busy[i] && !free_found) begin
                free_idx   = IDX_W'(i);
                free_found = 1'b1;
            end
        end
    end

    // The entry currently on offer is excluded so a held offer is never re-selected.
    always_comb begin
        cand = '0;
        for (int unsigned i = 0; i < SIZE; i++) begin
            cand[i] = busy[i] & ready[i] & ~(disp_valid && disp_idx == IDX_W'(i));
        end
    end

    always_comb begin
        sel_idx   = '0;
        sel_found = |cand;
        beaten    = 1'b0;
        for (int unsigned i = 0; i < SIZE; i++) begin
            beaten = 1'b0;
            for (int unsigned j = 0; j < SIZE; j++) begin
                if (cand[j] && older[j][i]) begin
                    beaten = 1'b1;
                end
            end
            if (cand[i] && !beaten) begin
                sel_idx = IDX_W'(i);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy  <= '0;
            older <= '0;
        end else if (flush) begin
            busy  <= '0;
            older <= '0;
        end else begin
            for (int unsigned i = 0; i < SIZE; i++) begin
                if (release_en && disp_idx == IDX_W'(i)) begin
                    busy[i] <= 1'b0;
                end
                if (alloc_gnt && alloc_idx == IDX_W'(i)) begin
                    busy[i] <= 1'b1;
                end
                // A new entry is younger than everything; stale bits of freed entries are masked by cand.
                for (int unsigned j = 0; j < SIZE; j++) begin
                    if (alloc_gnt && alloc_idx == IDX_W'(i)) begin
                        older[i][j] <= 1'b0;
                    end else if (alloc_gnt && alloc_idx == IDX_W'(j)) begin
                        older[i][j] <= 1'b1;
                    end
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            disp_valid <= 1'b0;
            disp_idx   <= '0;
        end else if (flush) begin
            disp_valid <= 1'b0;
            disp_idx   <= '0;
        end else if (!disp_valid || disp_ack) begin
            disp_valid <= sel_found;
            disp_idx   <= sel_idx;
        end
    end
endmodule

module rs_alloc_sched #(
    parameter int unsigned RS_V_SIZE = 4,
    parameter int unsigned RS_S_SIZE = 4,
    parameter int unsigned IDX_W     = 2
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 alloc_v_req,
    input  logic                 alloc_s_req,
    output logic                 alloc_v_gnt,
    output logic                 alloc_s_gnt,
    output logic [IDX_W-1:0]     alloc_v_idx,
    output logic [IDX_W-1:0]     alloc_s_idx,
    input  logic [RS_V_SIZE-1:0] ready_v,
    input  logic [RS_S_SIZE-1:0] ready_s,
    output logic                 disp_v_valid,
    output logic                 disp_s_valid,
    output logic [IDX_W-1:0]     disp_v_idx,
    output logic [IDX_W-1:0]     disp_s_idx,
    input  logic                 disp_v_ack,
    input  logic                 disp_s_ack,
    input  logic                 flush,
    output logic [RS_V_SIZE-1:0] busy_v,
    output logic [RS_S_SIZE-1:0] busy_s,
    output logic                 v_full,
    output logic                 s_full,
    output logic                 decoder_stall
);
    rs_pool #(.SIZE(RS_V_SIZE), .IDX_W(IDX_W)) u_pool_v (
        .clk        (clk),
        .rst_n      (rst_n),
        .flush      (flush),
        .alloc_req  (alloc_v_req),
        .alloc_gnt  (alloc_v_gnt),
        .alloc_idx  (alloc_v_idx),
        .ready      (ready_v),
        .disp_valid (disp_v_valid),
        .disp_idx   (disp_v_idx),
        .disp_ack   (disp_v_ack),
        .busy       (busy_v),
        .full       (v_full)
    );

    rs_pool #(.SIZE(RS_S_SIZE), .IDX_W(IDX_W)) u_pool_s (
        .clk        (clk),
        .rst_n      (rst_n),
        .flush      (flush),
        .alloc_req  (alloc_s_req),
        .alloc_gnt  (alloc_s_gnt),
        .alloc_idx  (alloc_s_idx),
        .ready      (ready_s),
        .disp_valid (disp_s_valid),
        .disp_idx   (disp_s_idx),
        .disp_ack   (disp_s_ack),
        .busy       (busy_s),
        .full       (s_full)
    );

    assign decoder_stall = (alloc_v_req & v_full) | (alloc_s_req & s_full) | flush;
endmodule

// File: tb/tb_rs_alloc_sched.sv
// Bench for rs_alloc_sched: directed scenarios with literal expectations plus
// randomized traffic checked each cycle against an allocation-stamp model.
module tb_rs_alloc_sched;
    localparam int N = 4;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         alloc_v_req = 1'b0, alloc_s_req = 1'b0;
    logic         alloc_v_gnt, alloc_s_gnt;
    logic [1:0]   alloc_v_idx, alloc_s_idx;
    logic [N-1:0] ready_v = '0, ready_s = '0;
    logic         disp_v_valid, disp_s_valid;
    logic [1:0]   disp_v_idx, disp_s_idx;
    logic         disp_v_ack = 1'b0, disp_s_ack = 1'b0;
    logic         flush = 1'b0;
    logic [N-1:0] busy_v, busy_s;
    logic         v_full, s_full, decoder_stall;

    int errors = 0;
    int checks = 0;

    rs_alloc_sched #(.RS_V_SIZE(N), .RS_S_SIZE(N), .IDX_W(2)) dut (
        .clk(clk), .rst_n(rst_n),
        .alloc_v_req(alloc_v_req), .alloc_s_req(alloc_s_req),
        .alloc_v_gnt(alloc_v_gnt), .alloc_s_gnt(alloc_s_gnt),
        .alloc_v_idx(alloc_v_idx), .alloc_s_idx(alloc_s_idx),
        .ready_v(ready_v), .ready_s(ready_s),
        .disp_v_valid(disp_v_valid), .disp_s_valid(disp_s_valid),
        .disp_v_idx(disp_v_idx), .disp_s_idx(disp_s_idx),
        .disp_v_ack(disp_v_ack), .disp_s_ack(disp_s_ack),
        .flush(flush),
        .busy_v(busy_v), .busy_s(busy_s),
        .v_full(v_full), .s_full(s_full),
        .decoder_stall(decoder_stall)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Model: per pool, occupancy, allocation stamp per entry, and the current offer.
    bit mbusy  [2][N];
    int mstamp [2][N];
    bit moff   [2];
    int midx   [2];
    int seq = 0;

    function automatic bit in_req(int p);
        return (p == 0) ? alloc_v_req : alloc_s_req;
    endfunction

    function automatic bit in_ack(int p);
        return (p == 0) ? disp_v_ack : disp_s_ack;
    endfunction

    function automatic logic [N-1:0] in_rdy(int p);
        return (p == 0) ? ready_v : ready_s;
    endfunction

    function automatic bit m_full(int p);
        for (int i = 0; i < N; i++) if (!mbusy[p][i]) return 1'b0;
        return 1'b1;
    endfunction

    function automatic int m_free(int p);
        for (int i = 0; i < N; i++) if (!mbusy[p][i]) return i;
        return 0;
    endfunction

    function automatic bit m_gnt(int p);
        return (rst_n === 1'b1) && in_req(p) && !m_full(p) && !flush;
    endfunction

    function automatic logic [N-1:0] m_busy(int p);
        logic [N-1:0] b;
        for (int i = 0; i < N; i++) b[i] = mbusy[p][i];
        return b;
    endfunction

    function automatic int m_pick(int p);
        logic [N-1:0] r;
        int best;
        r = in_rdy(p);
        best = -1;
        for (int i = 0; i < N; i++) begin
            if (mbusy[p][i] && r[i] && !(moff[p] && midx[p] == i))
                if (best < 0 || mstamp[p][i] < mstamp[p][best]) best = i;
        end
        return best;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int p = 0; p < 2; p++) begin
                for (int i = 0; i < N; i++) mbusy[p][i] = 1'b0;
                moff[p] = 1'b0;
                midx[p] = 0;
            end
        end else begin
            for (int p = 0; p < 2; p++) begin
                bit g;
                int gi, sel;
                g   = m_gnt(p);
                gi  = m_free(p);
                sel = m_pick(p);
                if (flush) begin
                    for (int i = 0; i < N; i++) mbusy[p][i] = 1'b0;
                    moff[p] = 1'b0;
                    midx[p] = 0;
                end else begin
                    if (moff[p] && in_ack(p)) mbusy[p][midx[p]] = 1'b0;
                    if (g) begin
                        mbusy[p][gi]  = 1'b1;
                        mstamp[p][gi] = seq;
                        seq++;
                    end
                    if (!moff[p] || in_ack(p)) begin
                        moff[p] = (sel >= 0);
                        midx[p] = (sel >= 0) ? sel : 0;
                    end
                end
            end
        end
    end

    always @(negedge clk) begin
        chk("v_gnt",  alloc_v_gnt,  m_gnt(0));
        chk("v_idx",  alloc_v_idx,  m_gnt(0) ? m_free(0) : 0);
        chk("s_gnt",  alloc_s_gnt,  m_gnt(1));
        chk("s_idx",  alloc_s_idx,  m_gnt(1) ? m_free(1) : 0);
        chk("busy_v", busy_v,       m_busy(0));
        chk("busy_s", busy_s,       m_busy(1));
        chk("v_full", v_full,       m_full(0));
        chk("s_full", s_full,       m_full(1));
        chk("disp_v_valid", disp_v_valid, moff[0]);
        chk("disp_v_idx",   disp_v_idx,   midx[0]);
        chk("disp_s_valid", disp_s_valid, moff[1]);
        chk("disp_s_idx",   disp_s_idx,   midx[1]);
        chk("stall", decoder_stall,
            (alloc_v_req && m_full(0)) || (alloc_s_req && m_full(1)) || flush);
    end

    initial begin
        #500000;
        $display("FAIL timeout: simulation did not finish, got running expected done");
        $fatal(1);
    end

    int got_ord [3];
    int n;

    initial begin
        // reset holds grants low even with a request present
        alloc_v_req = 1'b1;
        @(negedge clk);
        chk("rst_v_gnt",  alloc_v_gnt,  0);
        chk("rst_busy_v", busy_v,       0);
        chk("rst_disp_v", disp_v_valid, 0);
        chk("rst_v_full", v_full,       0);
        tick();
        alloc_v_req = 1'b0;
        rst_n = 1'b1;

        // fill vector pool in order, then full/stall
        alloc_v_req = 1'b1;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            if (k < 4) begin
                chk("fill_gnt", alloc_v_gnt, 1);
                chk("fill_idx", alloc_v_idx, k);
            end else begin
                chk("full_gnt",   alloc_v_gnt,   0);
                chk("full_flag",  v_full,        1);
                chk("full_stall", decoder_stall, 1);
            end
            tick();
        end

        // oldest ready among 1 and 3 is 1; back-to-back ack frees 1 then 3
        alloc_v_req = 1'b0;
        ready_v = 4'b1010;
        tick();
        disp_v_ack = 1'b1;
        @(negedge clk);
        chk("rdy_valid", disp_v_valid, 1);
        chk("rdy_idx1",  disp_v_idx,   1);
        tick();
        @(negedge clk);
        chk("rdy_idx3",  disp_v_idx,   3);
        chk("rdy_busy1", busy_v,       4'b1101);
        tick();
        disp_v_ack = 1'b0;
        @(negedge clk);
        chk("rdy_busy2", busy_v,       4'b0101);
        chk("rdy_idle",  disp_v_valid, 0);
        tick();

        // freeing while full does not grant that cycle, only the next
        alloc_v_req = 1'b1;
        ready_v = 4'b0100;
        @(negedge clk);
        chk("refill_idx1", alloc_v_idx, 1);
        tick();
        @(negedge clk);
        chk("refill_idx3", alloc_v_idx, 3);
        chk("offer2_idx",  disp_v_idx,  2);
        tick();
        disp_v_ack = 1'b1;
        @(negedge clk);
        chk("free_same_gnt", alloc_v_gnt, 0);
        chk("free_offer",    disp_v_idx,  2);
        tick();
        disp_v_ack = 1'b0;
        @(negedge clk);
        chk("free_next_gnt", alloc_v_gnt, 1);
        chk("free_next_idx", alloc_v_idx, 2);
        tick();
        alloc_v_req = 1'b0;

        // flush beats alloc and ack in the same cycle
        ready_v = '0;
        alloc_s_req = 1'b1;
        ready_s = 4'b1111;
        tick();
        tick();
        disp_s_ack = 1'b1;
        flush = 1'b1;
        @(negedge clk);
        chk("flush_s_gnt", alloc_s_gnt,   0);
        chk("flush_stall", decoder_stall, 1);
        chk("flush_offer", disp_s_valid,  1);
        tick();
        flush = 1'b0;
        alloc_s_req = 1'b0;
        disp_s_ack = 1'b0;
        @(negedge clk);
        chk("post_flush_busy_s", busy_s,       0);
        chk("post_flush_busy_v", busy_v,       0);
        chk("post_flush_disp_s", disp_s_valid, 0);
        chk("post_flush_disp_v", disp_v_valid, 0);
        tick();

        // reallocated entry 0 is younger than 1 and 2
        alloc_v_req = 1'b1;
        tick();
        tick();
        tick();
        alloc_v_req = 1'b0;
        ready_v = 4'b0001;
        tick();
        disp_v_ack = 1'b1;
        @(negedge clk);
        chk("age_first", disp_v_idx, 0);
        tick();
        disp_v_ack = 1'b0;
        ready_v = '0;
        alloc_v_req = 1'b1;
        @(negedge clk);
        chk("age_realloc", alloc_v_idx, 0);
        tick();
        alloc_v_req = 1'b0;
        ready_v = 4'b1111;
        disp_v_ack = 1'b1;
        n = 0;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            if (disp_v_valid && n < 3) begin
                got_ord[n] = disp_v_idx;
                n++;
            end
            tick();
        end
        disp_v_ack = 1'b0;
        chk("age_count", n, 3);
        chk("age_ord0", got_ord[0], 1);
        chk("age_ord1", got_ord[1], 2);
        chk("age_ord2", got_ord[2], 0);

        // asynchronous reset during an offer
        alloc_v_req = 1'b1;
        tick();
        alloc_v_req = 1'b0;
        tick();
        @(negedge clk);
        chk("arst_pre_valid", disp_v_valid, 1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_valid", disp_v_valid, 0);
        chk("arst_busy",  busy_v,       0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        for (int c = 0; c < 3000; c++) begin
            alloc_v_req = ($urandom_range(0, 3) != 0);
            alloc_s_req = ($urandom_range(0, 3) != 0);
            ready_v     = N'($urandom);
            ready_s     = N'($urandom);
            disp_v_ack  = $urandom_range(0, 1) == 1;
            disp_s_ack  = $urandom_range(0, 1) == 1;
            flush       = ($urandom_range(0, 49) == 0);
            tick();
        end
        flush = 1'b0;
        @(negedge clk);
        #1;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
